pio_write_arbiter: RTL and testbench
====================================

// Module: pio_write_arbiter
// PURPOSE
//  Shares one Avalon-MM PIO-style slave port (2-bit address, chipselect, write_n, 32-bit data) among NUM_REQ
//  on-chip requesters, e.g. Lorenz solver parameter loaders and HPS-bridge shadow logic.
//  Round-robin arbitration, one single-cycle access per grant, optional guard interval between accesses.
//  The PIO output stays stable for the downstream datapath during the guard interval.
// PARAMETERS
//  NUM_REQ       4   number of requesters (2..8)
//  DATA_W        27  payload width; zero-extended to 32 on writes, low DATA_W bits taken on reads
//  ADDR_W        2   slave address width
//  GUARD_CYCLES  0   idle cycles enforced after each access (0 = none, max 255)
// PORTS
//  clk          in   1               system clock; all logic on rising edge
//  reset        in   1               asynchronous, active-high reset
//  req          in   NUM_REQ         per-requester access request, held until ack
//  req_wr       in   NUM_REQ         1 = write, 0 = read
//  req_addr     in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
//  ack          out  NUM_REQ         one-cycle completion pulse, one-hot
//  rdata        out  DATA_W          read result, valid while the matching ack is high
//  busy         out  1               high in ACCESS or GUARD
//  grant_id     out  3               index of the last granted requester
//  s_address    out  ADDR_W          slave address
//  s_chipselect out  1               slave chipselect
//  s_write_n    out  1               slave write strobe, active low
//  s_writedata  out  32              slave write data
//  s_readdata   in   32              slave read data, combinational on s_address (read latency 0)
// BEHAVIOUR
//  Reset values: ack=0, rdata=0, busy=0, grant_id=0, s_address=0, s_chipselect=0, s_write_n=1,
//    s_writedata=0, rr_ptr=0, state=IDLE. Reset asserted mid-access aborts it immediately. No ack is
//    issued for the aborted access, and the bus is released at once.
//  FSM states: IDLE, ACCESS, GUARD.
//    IDLE:   if any req is high, pick the winner. Register grant_id, address, data and direction.
//            Go to ACCESS. Otherwise stay in IDLE.
//    ACCESS: exactly 1 cycle. Drive s_chipselect=1 and s_address. For a write, s_write_n=0 and
//            s_writedata={0,wdata}. For a read, s_write_n=1 and s_readdata[DATA_W-1:0] is captured
//            into rdata at the end of the cycle. Next state is GUARD if GUARD_CYCLES>0, else IDLE.
//    GUARD:  down-counter loaded with GUARD_CYCLES-1 on entry. Return to IDLE when the count is 0.
//            Bus is idle and no grants are made.
//  Outside ACCESS: s_chipselect=0 and s_write_n=1. Address and data hold their last values.
//  ack[grant_id] pulses for 1 cycle in the cycle after ACCESS. rdata updates in the same cycle and
//    holds until the next read.
//  Latency: req rises at cycle 0 in IDLE -> ACCESS at cycle 1 -> ack at cycle 2.
//    With GUARD_CYCLES=0, throughput is one access every 2 cycles.
//  Round-robin: search starts at (rr_ptr), and rr_ptr becomes winner+1 mod NUM_REQ after each grant.
//    The winner is the first requester with req=1 in search order. After reset, requester 0 has
//    top priority.
//  Requester contract: hold req and payload until ack, then drop req in the ack cycle or the cycle after.
//    Payload is latched at grant, so later changes have no effect on the access in flight.
//    A req held high through ack is treated as a new request and re-arbitrated fairly.
//  A req withdrawn before grant is ignored, with no access and no ack.
//    Withdrawal after grant does not cancel the access, and ack is still pulsed.
//  Simultaneous requests: exactly one grant per IDLE decision. No requester waits more than
//    NUM_REQ-1 other accesses.
// STRUCTURE
//  Shared package pio_arb_pkg: state enum {IDLE, ACCESS, GUARD}, GUARD counter width (8),
//    PIO_BUS_W = 32, and a clog2 helper for the pointer width.
//  Sub-module rr_priority_pick: purely combinational. Inputs are the req vector and rr_ptr.
//    Outputs are a one-hot winner and its index. Instantiated once.
// TESTING
//  1. Single write: req[2]=1, wr=1, addr=0, wdata=27'h5A5A5A.
//     -> cycle 1: s_chipselect=1, s_write_n=0, s_writedata=32'h005A5A5A. cycle 2: ack=4'b0100.
//  2. Contention from reset: req=4'b1111, all writes, held after each ack.
//     -> grant order 0,1,2,3,0 with 2-cycle spacing.
//  3. Guard interval: GUARD_CYCLES=3, two back-to-back requesters.
//     -> second ACCESS begins exactly 5 cycles after the first (ACCESS, 3×GUARD, IDLE).
//  4. Read: slave returns 32'hFFFF_FFFF on addr 0, req[1] read.
//     -> rdata=27'h7FFFFFF together with ack[1]. s_write_n stays 1 throughout.
//  5. Reset during ACCESS: assert reset in the ACCESS cycle.
//     -> same cycle: s_chipselect=0, s_write_n=1, no ack. After release, req=4'b1000 is granted
//        first, then rr_ptr=0.
//  6. Withdrawn request: req[3] pulses for 1 cycle while GUARD is active.
//     -> no access and no ack. Payload change after grant is ignored: original wdata appears on the bus.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared definitions for the PIO write arbiter: FSM state encoding, bus and
// counter widths, and a pointer-width helper.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GUARD  = 2'd2
    } arb_state_t;

    localparam int GUARD_CNT_W = 8;
    localparam int PIO_BUS_W   = 32;
    localparam int GRANT_ID_W  = 3;

    // Bits needed to index 'value' requesters; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 32'sd1;
        while ((32'sd1 << width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: scans the request vector starting at
// rr_ptr and returns the first asserted requester as one-hot and as index.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               winner_valid
);

    logic [NUM_REQ-1:0] onehot_base_s;
    assign onehot_base_s = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Walk the requesters in rotated order and keep the first hit.
    always_comb begin
        int         offs;
        logic [PTR_W-1:0] cand;
        logic       hit;
        logic       found;
        logic [PTR_W-1:0] pick;
        offs  = 32'sd0;
        cand  = '0;
        hit   = 1'b0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            offs  = int'(rr_ptr) + k;
            offs  = (offs >= NUM_REQ) ? (offs - NUM_REQ) : offs;
            cand  = offs[PTR_W-1:0];
            hit   = ~found & req[cand];
            pick  = hit ? cand : pick;
            found = found | hit;
        end
        winner_idx    = pick;
        winner_valid  = found;
        winner_onehot = found ? (onehot_base_s << pick) : '0;
    end

endmodule

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO slave port among NUM_REQ
// requesters. One single-cycle access per grant, optional guard interval.
// Bus outputs are registered, so address/data stay put between accesses.
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 27,
    parameter int ADDR_W       = 2,
    parameter int GUARD_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy,
    output logic [GRANT_ID_W-1:0]       grant_id,
    output logic [ADDR_W-1:0]           s_address,
    output logic                        s_chipselect,
    output logic                        s_write_n,
    output logic [PIO_BUS_W-1:0]        s_writedata,
    input  logic [PIO_BUS_W-1:0]        s_readdata
);

    localparam int PTR_W = clog2_min1(NUM_REQ);
    localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD =
        (GUARD_CYCLES > 32'sd0) ? GUARD_CNT_W'(GUARD_CYCLES - 32'sd1) : '0;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 32'sd1);

    arb_state_t               state_r;
    arb_state_t               state_next_s;
    logic [PTR_W-1:0]         rr_ptr_r;
    logic [GUARD_CNT_W-1:0]   guard_cnt_r;
    logic [NUM_REQ-1:0]       grant_oh_r;
    logic                     wr_r;

    logic [NUM_REQ-1:0]       win_oh_s;
    logic [PTR_W-1:0]         win_idx_s;
    logic                     win_valid_s;
    logic                     grant_s;
    logic [ADDR_W-1:0]        sel_addr_s;
    logic [DATA_W-1:0]        sel_wdata_s;
    logic                     sel_wr_s;

    // Only the low DATA_W bits of the slave read bus carry payload.
    logic                     readdata_unused_s;
    assign readdata_unused_s = ^s_readdata;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req           (req),
        .rr_ptr        (rr_ptr_r),
        .winner_onehot (win_oh_s),
        .winner_idx    (win_idx_s),
        .winner_valid  (win_valid_s)
    );

    assign grant_s = (state_r == IDLE) && win_valid_s;

    // Route the winner's payload out of the packed request buses.
    always_comb begin
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_wr_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{win_oh_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{win_oh_s[i]}});
            sel_wr_s    = sel_wr_s    | (req_wr[i] & win_oh_s[i]);
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> (GUARD) -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (GUARD_CYCLES > 32'sd0) begin
                    state_next_s = GUARD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GUARD: begin
                if (guard_cnt_r == '0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GUARD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the winner at grant and advance the round-robin pointer past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= '0;
            grant_id   <= '0;
            grant_oh_r <= '0;
            wr_r       <= 1'b0;
        end else if (grant_s) begin
            rr_ptr_r   <= (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + PTR_W'(32'd1));
            grant_id   <= GRANT_ID_W'(win_idx_s);
            grant_oh_r <= win_oh_s;
            wr_r       <= sel_wr_s;
        end
    end

    // Slave bus: strobes live only in ACCESS, address/data hold between accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_address    <= '0;
            s_chipselect <= 1'b0;
            s_write_n    <= 1'b1;
            s_writedata  <= '0;
        end else if (grant_s) begin
            s_address    <= sel_addr_s;
            s_chipselect <= 1'b1;
            s_write_n    <= ~sel_wr_s;
            if (sel_wr_s) begin
                s_writedata <= PIO_BUS_W'(sel_wdata_s);
            end
        end else begin
            s_chipselect <= 1'b0;
            s_write_n    <= 1'b1;
        end
    end

    // Completion: ack pulse after ACCESS, read data captured at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack   <= '0;
            rdata <= '0;
        end else if (state_r == ACCESS) begin
            ack <= grant_oh_r;
            if (!wr_r) begin
                rdata <= s_readdata[DATA_W-1:0];
            end
        end else begin
            ack <= '0;
        end
    end

    // Guard interval down-counter, loaded as ACCESS completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_cnt_r <= '0;
        end else if (state_r == ACCESS) begin
            guard_cnt_r <= GUARD_LOAD;
        end else if ((state_r == GUARD) && (guard_cnt_r != '0)) begin
            guard_cnt_r <= guard_cnt_r - GUARD_CNT_W'(32'd1);
        end
    end

    // Busy flag follows the state the FSM is entering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next_s != IDLE);
        end
    end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Directed bench for pio_write_arbiter: one instance without guard interval
// and one with GUARD_CYCLES=3 share the same request inputs.
module tb_pio_write_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_wr;
    logic [7:0]   req_addr;
    logic [107:0] req_wdata;

    logic [3:0]   ack0, ack3;
    logic [26:0]  rdata0, rdata3;
    logic         busy0, busy3;
    logic [2:0]   gid0, gid3;
    logic [1:0]   sa0, sa3;
    logic         scs0, scs3;
    logic         swn0, swn3;
    logic [31:0]  swd0, swd3;
    logic [31:0]  srd0, srd3;

    int n_vec;
    int n_err;

    // Slave register file seen through a zero-latency read port.
    function automatic logic [31:0] slave_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'hFFFF_FFFF;
            2'd1:    return 32'h1234_5678;
            2'd2:    return 32'hA5A5_0F0F;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign srd0 = slave_rd(sa0);
    assign srd3 = slave_rd(sa3);

    pio_write_arbiter #(.NUM_REQ(4), .DATA_W(27), .ADDR_W(2), .GUARD_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack0), .rdata(rdata0), .busy(busy0), .grant_id(gid0),
        .s_address(sa0), .s_chipselect(scs0), .s_write_n(swn0), .s_writedata(swd0),
        .s_readdata(srd0)
    );

    pio_write_arbiter #(.NUM_REQ(4), .DATA_W(27), .ADDR_W(2), .GUARD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack3), .rdata(rdata3), .busy(busy3), .grant_id(gid3),
        .s_address(sa3), .s_chipselect(scs3), .s_write_n(swn3), .s_writedata(swd3),
        .s_readdata(srd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = 4'b0000;
        req_wr    = 4'b1111;
        req_addr  = 8'h00;
        req_wdata = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (ack0 !== 4'b0000) begin n_err++; $display("FAIL rst_ack: got %b expected 0000", ack0); end
        n_vec++; if (rdata0 !== 27'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", rdata0); end
        n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy0); end
        n_vec++; if (gid0 !== 3'd0) begin n_err++; $display("FAIL rst_gid: got %0d expected 0", gid0); end
        n_vec++; if (sa0 !== 2'd0) begin n_err++; $display("FAIL rst_addr: got %0d expected 0", sa0); end
        n_vec++; if (scs0 !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b expected 0", scs0); end
        n_vec++; if (swn0 !== 1'b1) begin n_err++; $display("FAIL rst_wn: got %b expected 1", swn0); end
        n_vec++; if (swd0 !== 32'h0) begin n_err++; $display("FAIL rst_wd: got %h expected 0", swd0); end
        n_vec++; if ({scs3, swn3, busy3} !== 3'b010) begin n_err++; $display("FAIL rst_g3: got %b expected 010", {scs3, swn3, busy3}); end
    endtask

    task automatic test_single_write();
        do_reset();
        req_wdata[2*27 +: 27] = 27'h05A5A5A;
        req_addr[2*2 +: 2]    = 2'd0;
        req = 4'b0100;
        step();
        n_vec++; if (scs0 !== 1'b1) begin n_err++; $display("FAIL sw_cs: got %b expected 1", scs0); end
        n_vec++; if (swn0 !== 1'b0) begin n_err++; $display("FAIL sw_wn: got %b expected 0", swn0); end
        n_vec++; if (swd0 !== 32'h005A5A5A) begin n_err++; $display("FAIL sw_wd: got %h expected 005a5a5a", swd0); end
        n_vec++; if (gid0 !== 3'd2) begin n_err++; $display("FAIL sw_gid: got %0d expected 2", gid0); end
        n_vec++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL sw_busy: got %b expected 1", busy0); end
        n_vec++; if (ack0 !== 4'b0000) begin n_err++; $display("FAIL sw_ack_early: got %b expected 0000", ack0); end
        step();
        req = 4'b0000;
        n_vec++; if (ack0 !== 4'b0100) begin n_err++; $display("FAIL sw_ack: got %b expected 0100", ack0); end
        n_vec++; if ({scs0, swn0, busy0} !== 3'b010) begin n_err++; $display("FAIL sw_release: got %b expected 010", {scs0, swn0, busy0}); end
        step();
        n_vec++; if (ack0 !== 4'b0000) begin n_err++; $display("FAIL sw_ack_pulse: got %b expected 0000", ack0); end
        n_vec++; if (swd0 !== 32'h005A5A5A) begin n_err++; $display("FAIL sw_wd_hold: got %h expected 005a5a5a", swd0); end
    endtask

    task automatic test_contention();
        logic [31:0] lane_data [4];
        lane_data[0] = 32'h0100_0001;
        lane_data[1] = 32'h0200_0002;
        lane_data[2] = 32'h0300_0003;
        lane_data[3] = 32'h0400_0004;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_wdata[k*27 +: 27] = lane_data[k][26:0];
            req_addr[k*2 +: 2]    = 2'(k);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            n_vec++; if (scs0 !== 1'b1 || gid0 !== 3'(n % 4)) begin n_err++; $display("FAIL rr_grant%0d: got cs=%b id=%0d expected cs=1 id=%0d", n, scs0, gid0, n % 4); end
            n_vec++; if (swd0 !== lane_data[n % 4] || sa0 !== 2'(n % 4)) begin n_err++; $display("FAIL rr_payload%0d: got %h@%0d expected %h@%0d", n, swd0, sa0, lane_data[n % 4], n % 4); end
            step();
            if (n == 4) begin
                req = 4'b0000;
            end
            n_vec++; if (ack0 !== (4'b0001 << (n % 4)) || scs0 !== 1'b0) begin n_err++; $display("FAIL rr_ack%0d: got ack=%b cs=%b expected ack=%b cs=0", n, ack0, scs0, 4'b0001 << (n % 4)); end
        end
        step();
        n_vec++; if (scs0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL rr_idle: got cs=%b busy=%b expected 0 0", scs0, busy0); end
    endtask

    task automatic test_guard();
        do_reset();
        req_wdata[0 +: 27]  = 27'h0000011;
        req_wdata[27 +: 27] = 27'h0000022;
        req = 4'b0011;
        step();
        n_vec++; if (scs3 !== 1'b1 || gid3 !== 3'd0) begin n_err++; $display("FAIL gd_first: got cs=%b id=%0d expected 1 0", scs3, gid3); end
        step();
        req = 4'b0010;
        n_vec++; if (ack3 !== 4'b0001 || scs3 !== 1'b0 || busy3 !== 1'b1) begin n_err++; $display("FAIL gd_ack0: got ack=%b cs=%b busy=%b expected 0001 0 1", ack3, scs3, busy3); end
        step();
        step();
        n_vec++; if (scs3 !== 1'b0 || busy3 !== 1'b1) begin n_err++; $display("FAIL gd_hold: got cs=%b busy=%b expected 0 1", scs3, busy3); end
        step();
        n_vec++; if (scs3 !== 1'b0 || busy3 !== 1'b0) begin n_err++; $display("FAIL gd_idle: got cs=%b busy=%b expected 0 0", scs3, busy3); end
        step();
        n_vec++; if (scs3 !== 1'b1 || gid3 !== 3'd1 || swd3 !== 32'h0000_0022) begin n_err++; $display("FAIL gd_second: got cs=%b id=%0d wd=%h expected 1 1 00000022", scs3, gid3, swd3); end
        step();
        req = 4'b0000;
        n_vec++; if (ack3 !== 4'b0010) begin n_err++; $display("FAIL gd_ack1: got %b expected 0010", ack3); end
    endtask

    task automatic test_read();
        do_reset();
        req_wr = 4'b1101;
        req_addr[2 +: 2] = 2'd0;
        req_wdata[3*27 +: 27] = 27'h0000333;
        req = 4'b0010;
        step();
        n_vec++; if (scs0 !== 1'b1 || swn0 !== 1'b1 || sa0 !== 2'd0) begin n_err++; $display("FAIL rd_access: got cs=%b wn=%b a=%0d expected 1 1 0", scs0, swn0, sa0); end
        step();
        n_vec++; if (ack0 !== 4'b0010 || rdata0 !== 27'h7FFFFFF) begin n_err++; $display("FAIL rd_data: got ack=%b rdata=%h expected 0010 7ffffff", ack0, rdata0); end
        n_vec++; if (swn0 !== 1'b1) begin n_err++; $display("FAIL rd_wn: got %b expected 1", swn0); end
        req = 4'b1000;
        step();
        n_vec++; if (scs0 !== 1'b1 || swn0 !== 1'b0 || gid0 !== 3'd3) begin n_err++; $display("FAIL rd_wr3: got cs=%b wn=%b id=%0d expected 1 0 3", scs0, swn0, gid0); end
        step();
        n_vec++; if (ack0 !== 4'b1000 || rdata0 !== 27'h7FFFFFF) begin n_err++; $display("FAIL rd_hold: got ack=%b rdata=%h expected 1000 7ffffff", ack0, rdata0); end
        req_wr = 4'b1100;
        req_addr[0 +: 2] = 2'd2;
        req = 4'b0001;
        step();
        n_vec++; if (scs0 !== 1'b1 || swn0 !== 1'b1 || sa0 !== 2'd2) begin n_err++; $display("FAIL rd2_access: got cs=%b wn=%b a=%0d expected 1 1 2", scs0, swn0, sa0); end
        step();
        req = 4'b0000;
        n_vec++; if (ack0 !== 4'b0001 || rdata0 !== 27'h5A50F0F) begin n_err++; $display("FAIL rd2_data: got ack=%b rdata=%h expected 0001 5a50f0f", ack0, rdata0); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req_wdata[0 +: 27]    = 27'h0000AAA;
        req_wdata[3*27 +: 27] = 27'h0000BBB;
        req = 4'b0001;
        step();
        n_vec++; if (scs0 !== 1'b1) begin n_err++; $display("FAIL ra_access: got cs=%b expected 1", scs0); end
        reset = 1'b1;
        #1;
        n_vec++; if ({scs0, swn0, busy0} !== 3'b010 || ack0 !== 4'b0000) begin n_err++; $display("FAIL ra_abort: got cs/wn/busy=%b ack=%b expected 010 0000", {scs0, swn0, busy0}, ack0); end
        req = 4'b1000;
        step();
        n_vec++; if (ack0 !== 4'b0000 || scs0 !== 1'b0) begin n_err++; $display("FAIL ra_noack: got ack=%b cs=%b expected 0000 0", ack0, scs0); end
        reset = 1'b0;
        step();
        n_vec++; if (scs0 !== 1'b1 || gid0 !== 3'd3 || swd0 !== 32'h0000_0BBB) begin n_err++; $display("FAIL ra_grant3: got cs=%b id=%0d wd=%h expected 1 3 00000bbb", scs0, gid0, swd0); end
        step();
        n_vec++; if (ack0 !== 4'b1000) begin n_err++; $display("FAIL ra_ack3: got %b expected 1000", ack0); end
        req = 4'b1001;
        step();
        n_vec++; if (scs0 !== 1'b1 || gid0 !== 3'd0) begin n_err++; $display("FAIL ra_ptr_wrap: got cs=%b id=%0d expected 1 0", scs0, gid0); end
        step();
        req = 4'b0000;
        n_vec++; if (ack0 !== 4'b0001) begin n_err++; $display("FAIL ra_ack0: got %b expected 0001", ack0); end
    endtask

    task automatic test_withdraw_and_payload();
        do_reset();
        req_addr[0 +: 2]   = 2'd1;
        req_wdata[0 +: 27] = 27'h0ABCDEF;
        req = 4'b0001;
        step();
        req_wdata[0 +: 27] = 27'h1111111;
        req_addr[0 +: 2]   = 2'd3;
        #1;
        n_vec++; if (scs3 !== 1'b1 || swd3 !== 32'h00AB_CDEF || sa3 !== 2'd1) begin n_err++; $display("FAIL wd_latched: got cs=%b wd=%h a=%0d expected 1 00abcdef 1", scs3, swd3, sa3); end
        step();
        n_vec++; if (ack3 !== 4'b0001) begin n_err++; $display("FAIL wd_ack0: got %b expected 0001", ack3); end
        req = 4'b1000;
        step();
        req = 4'b0000;
        for (int n = 0; n < 6; n++) begin
            n_vec++; if (scs3 !== 1'b0 || ack3 !== 4'b0000) begin n_err++; $display("FAIL wd_ignored%0d: got cs=%b ack=%b expected 0 0000", n, scs3, ack3); end
            step();
        end
        n_vec++; if (gid3 !== 3'd0 || swd3 !== 32'h00AB_CDEF) begin n_err++; $display("FAIL wd_final: got id=%0d wd=%h expected 0 00abcdef", gid3, swd3); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req       = 4'b0000;
        req_wr    = 4'b1111;
        req_addr  = 8'h00;
        req_wdata = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_guard();
        test_read();
        test_reset_mid_access();
        test_withdraw_and_payload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
